// File: rtl/gyro_pkg.sv
// Shared states and sensor command words for the yaw-rate reader.
// Pure declarations; no timing or flow-control behaviour of its own.
// Commands are {register/rw byte, data byte}; reads use bit 15 set.
package gyro_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG1,
        CFG2,
        CFG3,
        WAIT_INT,
        RD_L,
        RD_H
    } reader_state_t;

    localparam logic [15:0] CMD_INT_EN = 16'h0D02;
    localparam logic [15:0] CMD_ODR    = 16'h1160;
    localparam logic [15:0] CMD_ROUND  = 16'h1440;
    localparam logic [15:0] CMD_YAW_L  = 16'hA600;
    localparam logic [15:0] CMD_YAW_H  = 16'hA700;

    localparam int PWR_BIT_FAST = 9;
    localparam int PWR_BIT_FULL = 15;

endpackage

// File: rtl/spi_mnrch16.sv
// 16-bit SPI master, SCLK idle high, MOSI on fall, MISO sampled 1 clk after rise.
// Latency: snd to done = 1 + 33 half periods of 2^(SCLK_DIV_W-1) clks.
// Backpressure: snd while a frame is in flight is dropped; no queueing.
module spi_mnrch16 #(
    parameter int SCLK_DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] resp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int HW = SCLK_DIV_W - 1;
    localparam logic [HW-1:0] DIV_ONE = 1;
    localparam logic [5:0] LAST_TICK = 6'd33;

    logic          busy;
    logic [HW-1:0] div;
    logic [5:0]    hcnt;
    logic [5:0]    hnext;
    logic [15:0]   tx_sh;
    logic [15:0]   rx_sh;
    logic          smpl;
    logic          tick;

    assign tick  = busy && (&div);
    assign hnext = hcnt + 6'd1;

    // Half-period ticks: odd = SCLK fall, even = rise, 33rd = release SS_n.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            div   <= '0;
            hcnt  <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
            smpl  <= 1'b0;
            SS_n  <= 1'b1;
            SCLK  <= 1'b1;
            MOSI  <= 1'b0;
            done  <= 1'b0;
            resp  <= '0;
        end else begin
            done <= 1'b0;
            smpl <= 1'b0;
            if (smpl) begin
                rx_sh <= {rx_sh[14:0], MISO};
            end
            if (!busy) begin
                if (snd) begin
                    busy  <= 1'b1;
                    SS_n  <= 1'b0;
                    div   <= '0;
                    hcnt  <= '0;
                    tx_sh <= cmd;
                    rx_sh <= '0;
                end
            end else begin
                div <= div + DIV_ONE;
                if (tick) begin
                    hcnt <= hnext;
                    if (hnext == LAST_TICK) begin
                        busy <= 1'b0;
                        SS_n <= 1'b1;
                        MOSI <= 1'b0;
                        done <= 1'b1;
                        resp <= rx_sh;
                    end else if (hnext[0]) begin
                        SCLK  <= 1'b0;
                        MOSI  <= tx_sh[15];
                        tx_sh <= {tx_sh[14:0], 1'b0};
                    end else begin
                        SCLK <= 1'b1;
                        smpl <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/gyro_yaw_reader.sv
// Configures the inertial sensor after power-up, then reads yaw rate on each INT.
// Latency: INT to vld ~ 2 sync clks + two SPI frames + 1 clk.
// Backpressure: none downstream; INT changes during a read pair are not queued.
module gyro_yaw_reader
    import gyro_pkg::*;
#(
    parameter bit FAST_SIM   = 1'b1,
    parameter int SCLK_DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_done
);

    reader_state_t state;
    reader_state_t state_nxt;

    logic        int_s1;
    logic        int_s2;
    logic [15:0] timer;
    logic        timer_hit;
    logic [7:0]  low_byte;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic        resp_hi_unused;

    assign timer_hit      = FAST_SIM ? timer[PWR_BIT_FAST] : timer[PWR_BIT_FULL];
    assign resp_hi_unused = ^resp[15:8];

    spi_mnrch16 #(
        .SCLK_DIV_W (SCLK_DIV_W)
    ) u_spi (
        .clk  (clk),
        .rst  (rst),
        .snd  (snd),
        .cmd  (cmd),
        .done (done),
        .resp (resp),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            int_s1    <= 1'b0;
            int_s2    <= 1'b0;
            timer     <= '0;
            low_byte  <= '0;
            yaw_rt    <= '0;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            int_s1 <= INT;
            int_s2 <= int_s1;
            vld    <= 1'b0;
            // Timer freezes at the threshold, so it can never wrap.
            if (state == PWR_WAIT && !timer_hit) begin
                timer <= timer + 16'd1;
            end
            if (done) begin
                case (state)
                    CFG3:    init_done <= 1'b1;
                    RD_L:    low_byte  <= resp[7:0];
                    RD_H: begin
                        yaw_rt <= {resp[7:0], low_byte};
                        vld    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        snd       = 1'b0;
        cmd       = '0;
        case (state)
            PWR_WAIT: if (timer_hit) begin
                snd       = 1'b1;
                cmd       = CMD_INT_EN;
                state_nxt = CFG1;
            end
            CFG1: if (done) begin
                snd       = 1'b1;
                cmd       = CMD_ODR;
                state_nxt = CFG2;
            end
            CFG2: if (done) begin
                snd       = 1'b1;
                cmd       = CMD_ROUND;
                state_nxt = CFG3;
            end
            CFG3: if (done) begin
                state_nxt = WAIT_INT;
            end
            // Level-sensitive: a still-high INT immediately starts another pair.
            WAIT_INT: if (int_s2) begin
                snd       = 1'b1;
                cmd       = CMD_YAW_L;
                state_nxt = RD_L;
            end
            RD_L: if (done) begin
                snd       = 1'b1;
                cmd       = CMD_YAW_H;
                state_nxt = RD_H;
            end
            RD_H: if (done) begin
                state_nxt = WAIT_INT;
            end
            default: state_nxt = PWR_WAIT;
        endcase
    end

endmodule
